// File: rtl/iob_axi_mem_responder.sv
// AXI4 slave memory: one burst at a time (write or read) into a word-addressed RAM.
// Simultaneous AW/AR requests alternate between write and read via a priority bit.
module iob_axi_mem_responder #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 16,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int B      = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RFETCH, RDATA} state_t;

    logic [AXI_DATA_W-1:0] mem [0:(2**MEM_ADDR_W)-1];

    state_t                  state_q, state_d;
    logic                    prio_w_q, prio_w_d;
    logic [AXI_ID_W-1:0]     id_q, id_d;
    logic [MEM_ADDR_W-1:0]   idx_q, idx_d;
    logic [AXI_LEN_W-1:0]    len_q, len_d;
    logic [AXI_LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]              burst_q, burst_d;
    logic                    err_q, err_d;
    logic                    bvalid_q, bvalid_d;
    logic [AXI_ID_W-1:0]     bid_q, bid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    rvalid_q, rvalid_d;
    logic [AXI_ID_W-1:0]     rid_q, rid_d;
    logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    rlast_q, rlast_d;

    logic                    aw_sel_s, ar_sel_s, w_fire_s, last_cnt_s;
    logic [MEM_ADDR_W-1:0]   idx_next_s;
    logic                    unused_addr_s;

    // Grants are only offered in IDLE and never while reset is applied
    assign aw_sel_s = (state_q == IDLE) & ~rst_i & axi_awvalid_i & (~axi_arvalid_i | prio_w_q);
    assign ar_sel_s = (state_q == IDLE) & ~rst_i & axi_arvalid_i & (~axi_awvalid_i | ~prio_w_q);
    assign w_fire_s   = (state_q == WRITE) & axi_wvalid_i;
    assign last_cnt_s = (cnt_q == len_q);
    assign idx_next_s = (burst_q == BURST_FIXED) ? idx_q : idx_q + MEM_ADDR_W'(1);
    assign unused_addr_s = ^{axi_awaddr_i, axi_araddr_i};

    assign axi_awready_o = aw_sel_s;
    assign axi_arready_o = ar_sel_s;
    assign axi_wready_o  = (state_q == WRITE);
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bid_o     = bid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rid_o     = rid_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rlast_o   = rlast_q;

    // Next-state and registered-output logic for the burst FSM
    always_comb begin
        state_d  = state_q;
        prio_w_d = prio_w_q;
        id_d     = id_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        err_d    = err_q;
        bvalid_d = bvalid_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (state_q)
            IDLE: begin
                if (axi_awvalid_i && axi_arvalid_i) begin
                    prio_w_d = ~prio_w_q;
                end else begin
                    prio_w_d = prio_w_q;
                end
                if (aw_sel_s) begin
                    id_d    = axi_awid_i;
                    idx_d   = axi_awaddr_i[MEM_ADDR_W+B-1:B];
                    len_d   = axi_awlen_i;
                    burst_d = axi_awburst_i;
                    err_d   = (axi_awsize_i != 3'(B));
                    cnt_d   = {AXI_LEN_W{1'b0}};
                    state_d = WRITE;
                end else if (ar_sel_s) begin
                    id_d    = axi_arid_i;
                    idx_d   = axi_araddr_i[MEM_ADDR_W+B-1:B];
                    len_d   = axi_arlen_i;
                    burst_d = axi_arburst_i;
                    err_d   = (axi_arsize_i != 3'(B));
                    cnt_d   = {AXI_LEN_W{1'b0}};
                    state_d = RFETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // Burst closes on whichever of wlast or the beat count comes first
                if (w_fire_s && (last_cnt_s || axi_wlast_i)) begin
                    bvalid_d = 1'b1;
                    bid_d    = id_q;
                    bresp_d  = (err_q || (axi_wlast_i != last_cnt_s)) ? RESP_SLVERR : RESP_OKAY;
                    state_d  = WRESP;
                end else if (w_fire_s) begin
                    cnt_d = cnt_q + AXI_LEN_W'(1);
                    idx_d = idx_next_s;
                end else begin
                    state_d = WRITE;
                end
            end
            WRESP: begin
                if (axi_bready_i) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = WRESP;
                end
            end
            RFETCH: begin
                rvalid_d = 1'b1;
                rid_d    = id_q;
                rdata_d  = err_q ? {AXI_DATA_W{1'b0}} : mem[idx_q];
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                rlast_d  = last_cnt_s;
                state_d  = RDATA;
            end
            RDATA: begin
                if (axi_rready_i && rlast_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = IDLE;
                end else if (axi_rready_i) begin
                    rvalid_d = 1'b0;
                    cnt_d    = cnt_q + AXI_LEN_W'(1);
                    idx_d    = idx_next_s;
                    state_d  = RFETCH;
                end else begin
                    state_d = RDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            prio_w_q <= 1'b1;
            id_q     <= {AXI_ID_W{1'b0}};
            idx_q    <= {MEM_ADDR_W{1'b0}};
            len_q    <= {AXI_LEN_W{1'b0}};
            cnt_q    <= {AXI_LEN_W{1'b0}};
            burst_q  <= 2'b00;
            err_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= {AXI_ID_W{1'b0}};
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rid_q    <= {AXI_ID_W{1'b0}};
            rdata_q  <= {AXI_DATA_W{1'b0}};
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_w_q <= prio_w_d;
            id_q     <= id_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            bvalid_q <= bvalid_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    // Byte-enabled RAM write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_fire_s && !err_q) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_wstrb_i[i]) begin
                    mem[idx_q][8*i +: 8] <= axi_wdata_i[8*i +: 8];
                end
            end
        end
    end
endmodule
